// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encodings, state type and helpers for usr_param
//
// Purpose : 3-bit operation codes for the universal shift register, the
//           burst FSM state type, and a classifier for burst-capable modes.
// Ports   : none (package).

package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_t;

  // Modes that move bits and may therefore be repeated by a burst.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

endpackage

// File: rtl/usr_bit_sel.sv
// rtl/usr_bit_sel.sv - per-bit next-value selector of the universal shift register
//
// Purpose : picks the next value of one register bit from its own value,
//           its neighbours or the parallel load bit.
// Ports   : self_bit  - current value of this bit
//           left_bit  - next-higher bit (out[i+1]); boundary value for the MSB
//           right_bit - next-lower bit (out[i-1]); boundary value for bit 0
//           load_bit  - parallel load data for this bit
//           mode      - effective operation (hold when not stepping)
//           next_bit  - value this bit takes at the next edge

module usr_bit_sel
  import usr_pkg::*;
(
  input  logic       self_bit,
  input  logic       left_bit,
  input  logic       right_bit,
  input  logic       load_bit,
  input  logic [2:0] mode,
  output logic       next_bit
);

  // Left shifts/rotates pull from below, right shifts/rotates pull from above;
  // the parent resolves what "below bit 0" and "above the MSB" mean per mode.
  always_comb begin
    next_bit = self_bit;
    case (mode)
      MODE_SHL, MODE_ROL:           next_bit = right_bit;
      MODE_SHR, MODE_ROR, MODE_ASR: next_bit = left_bit;
      MODE_LOAD:                    next_bit = load_bit;
      default:                      next_bit = self_bit;
    endcase
  end

endmodule

// File: rtl/usr_param.sv
// rtl/usr_param.sv - parametrised universal shift register with burst-shift engine
//
// Purpose : WIDTH-bit shift/rotate/load register with clock enable and an
//           autonomous engine that applies one shift mode burst_len times.
// Ports   : clk, reset (async, active low)
//           en          - single-step enable in IDLE
//           mode        - operation select (usr_pkg MODE_*)
//           q           - parallel load data
//           sin_lsb     - serial input into bit 0 on shift left
//           sin_msb     - serial input into the MSB on logical shift right
//           burst_start - request a burst of burst_len shifts
//           burst_len   - burst shift count
//           out         - register contents
//           sout_msb    - out[WIDTH-1]
//           sout_lsb    - out[0]
//           busy        - burst in progress (registered)
//           done        - one-cycle pulse after the last burst shift (registered)

module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic             burst_start,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  usr_state_t       state;
  logic [2:0]       run_mode;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic [2:0]       eff_mode;
  logic             bit0_right;
  logic             msb_left;
  logic [WIDTH-1:0] right_vec;
  logic [WIDTH-1:0] left_vec;
  logic [WIDTH-1:0] nxt;

  assign accept = (state == ST_IDLE) && burst_start &&
                  (burst_len != '0) && is_shift_mode(mode);

  // An accepted burst_start wins over single-step, so out holds on that edge.
  always_comb begin
    eff_mode = MODE_HOLD;
    if (state == ST_RUN) begin
      eff_mode = run_mode;
    end else if (!accept && en) begin
      eff_mode = mode;
    end
  end

  // Boundary neighbours: what enters bit 0 and the MSB depends on the mode.
  always_comb begin
    bit0_right = sin_lsb;
    if (eff_mode == MODE_ROL) begin
      bit0_right = out[WIDTH-1];
    end
    msb_left = sin_msb;
    if (eff_mode == MODE_ROR) begin
      msb_left = out[0];
    end else if (eff_mode == MODE_ASR) begin
      msb_left = out[WIDTH-1];
    end
  end

  assign right_vec = {out[WIDTH-2:0], bit0_right};
  assign left_vec  = {msb_left, out[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_bit_sel u_sel (
      .self_bit  (out[i]),
      .left_bit  (left_vec[i]),
      .right_bit (right_vec[i]),
      .load_bit  (q[i]),
      .mode      (eff_mode),
      .next_bit  (nxt[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      run_mode <= MODE_HOLD;
      cnt      <= '0;
      out      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      out  <= nxt;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            run_mode <= mode;
            cnt      <= burst_len;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt - CW'(1);
          // cnt never reaches 0 here: bursts are only accepted with len != 0.
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sout_msb = out[WIDTH-1];
  assign sout_lsb = out[0];

endmodule

// File: tb/tb_usr_param.sv
// tb/tb_usr_param.sv - self-checking bench for usr_param (WIDTH=8)

module tb_usr_param;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  q = '0;
  logic          sin_lsb = 1'b0;
  logic          sin_msb = 1'b0;
  logic          burst_start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic [W-1:0]  out;
  logic          sout_msb, sout_lsb, busy, done;

  int checks = 0;
  int failures = 0;
  logic chk_on = 1'b0;

  usr_param #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .q(q),
    .sin_lsb(sin_lsb), .sin_msb(sin_msb), .burst_start(burst_start),
    .burst_len(burst_len), .out(out), .sout_msb(sout_msb),
    .sout_lsb(sout_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one operation on a value.
  function automatic logic [W-1:0] apply(input logic [W-1:0] v, input logic [2:0] m,
                                         input logic [W-1:0] d, input logic sl, input logic sm);
    case (m)
      3'd1: return {v[W-2:0], sl};
      3'd2: return {sm, v[W-1:1]};
      3'd3: return d;
      3'd4: return {v[W-2:0], v[W-1]};
      3'd5: return {v[0], v[W-1:1]};
      3'd6: return W'($signed(v) >>> 1);
      default: return v;
    endcase
  endfunction

  // Model: remaining-shift count instead of any state machine.
  logic [W-1:0] m_out = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_rem = 0;
  logic [2:0]   m_mode = 3'b000;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 3'b000;
    end else if (m_rem > 0) begin
      m_out  = apply(m_out, m_mode, q, sin_lsb, sin_msb);
      m_rem  = m_rem - 1;
      m_busy = (m_rem > 0);
      m_done = (m_rem == 0);
    end else begin
      m_done = 1'b0;
      if (burst_start && burst_len != 0 && (mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        m_mode = mode;
        m_rem  = int'(burst_len);
        m_busy = 1'b1;
      end else if (en) begin
        m_out = apply(m_out, mode, q, sin_lsb, sin_msb);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_out", 32'(out), 32'(m_out));
      check("cyc_sout_msb", 32'(sout_msb), 32'(m_out[W-1]));
      check("cyc_sout_lsb", 32'(sout_lsb), 32'(m_out[0]));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic [W-1:0] d);
    en = e; mode = m; q = d;
  endtask

  task automatic burst(input logic [2:0] m, input logic [CW-1:0] len);
    burst_start = 1'b1; mode = m; burst_len = len;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_on = 1'b1;

    // Reset mid-cycle after a load
    drive(1, 3'b011, 8'hA5); tick;
    check("load_a5", 32'(out), 32'hA5);
    #2 reset = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'h00);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    tick; reset = 1'b1;

    // Single steps from 0x81
    drive(1, 3'b011, 8'h81); tick;
    check("load_81", 32'(out), 32'h81);
    sin_lsb = 1'b1; drive(1, 3'b001, 8'h00); tick;
    check("shl", 32'(out), 32'h03);
    drive(1, 3'b101, 8'h00); tick;
    check("ror", 32'(out), 32'h81);
    drive(1, 3'b110, 8'h00); tick;
    check("asr", 32'(out), 32'hC0);
    drive(1, 3'b111, 8'h00); tick;
    check("rsvd_hold", 32'(out), 32'hC0);
    drive(0, 3'b001, 8'h00); tick;
    check("en0_hold", 32'(out), 32'hC0);

    // Burst SHR x3 from 0xF0, mode/q scribbled during RUN
    drive(1, 3'b011, 8'hF0); tick;
    sin_msb = 1'b0; burst(3'b010, 4'd3); tick;
    check("burst_accept_busy", 32'(busy), 32'h1);
    check("burst_accept_out", 32'(out), 32'hF0);
    burst_start = 1'b0; drive(1, 3'b011, 8'hFF);
    tick; check("burst_s1", 32'(out), 32'h78);
    tick; check("burst_s2_busy", 32'(busy), 32'h1);
    tick;
    check("burst_end_out", 32'(out), 32'h1E);
    check("burst_end_done", 32'(done), 32'h1);
    check("burst_end_busy", 32'(busy), 32'h0);
    drive(0, 3'b000, 8'h00); tick;
    check("done_pulse_end", 32'(done), 32'h0);

    // Rejected bursts: len 0 steps normally, LOAD loads normally
    sin_lsb = 1'b0; en = 1'b1; burst(3'b001, 4'd0); tick;
    check("rej_len0_out", 32'(out), 32'h3C);
    check("rej_len0_busy", 32'(busy), 32'h0);
    burst(3'b011, 4'd3); q = 8'h5A; tick;
    check("rej_load_out", 32'(out), 32'h5A);
    check("rej_load_busy", 32'(busy), 32'h0);
    burst_start = 1'b0; drive(0, 3'b000, 8'h00); tick;
    check("rej_no_done", 32'(done), 32'h0);

    // Back-to-back ROL x8 bursts from 0x5A
    burst(3'b100, 4'd8); tick;
    burst_start = 1'b0;
    tick; check("rol_s1", 32'(out), 32'hB4);
    repeat (7) tick;
    check("b2b_first_done", 32'(done), 32'h1);
    check("b2b_first_out", 32'(out), 32'h5A);
    burst(3'b100, 4'd8); tick;
    check("b2b_reaccept_busy", 32'(busy), 32'h1);
    check("b2b_reaccept_done", 32'(done), 32'h0);
    burst_start = 1'b0;
    repeat (8) tick;
    check("b2b_second_done", 32'(done), 32'h1);
    check("b2b_second_out", 32'(out), 32'h5A);

    // Reset during a len=5 burst after its second shift
    drive(1, 3'b011, 8'h3C); tick;
    sin_lsb = 1'b1; en = 1'b0; burst(3'b001, 4'd5); tick;
    burst_start = 1'b0;
    tick; tick;
    check("mid_s2_out", 32'(out), 32'hF3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'h0);
    tick; reset = 1'b1;
    drive(0, 3'b000, 8'h00);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("mid_rst_no_done", 32'(done), 32'h0);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
